// File: rtl/axi_lite_reg_bank_pkg.sv
// Shared offsets, response codes, decode region type and byte-mask helper
// for the AXI4-Lite host register bank.
package axi_lite_reg_bank_pkg;

    localparam logic [31:0] OFF_VERSION    = 32'h0000_0000;
    localparam logic [31:0] OFF_PULSE      = 32'h0000_0004;
    localparam logic [31:0] OFF_EVT_STATUS = 32'h0000_0008;
    localparam logic [31:0] OFF_EVT_ENABLE = 32'h0000_000C;
    localparam logic [31:0] OFF_CTRL_BASE  = 32'h0000_0010;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        REG_VERSION    = 3'd0,
        REG_PULSE      = 3'd1,
        REG_EVT_STATUS = 3'd2,
        REG_EVT_ENABLE = 3'd3,
        REG_CTRL       = 3'd4,
        REG_STAT       = 3'd5,
        REG_NONE       = 3'd6
    } region_e;

    function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
        logic [31:0] mask;
        for (int b = 0; b < 4; b++) begin
            mask[8*b +: 8] = {8{strb[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/axi_lite_reg_bank_decode.sv
// Combinational byte-address to register region/index decoder; one instance
// serves the write address, another the read address.
module axi_lite_reg_bank_decode
    import axi_lite_reg_bank_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_CTRL   = 4,
    parameter int NUM_STAT   = 4
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output region_e               region_o,
    output logic [31:0]           index_o,
    output logic                  valid_o
);

    localparam logic [31:0] CTRL_END = OFF_CTRL_BASE + 32'(4 * NUM_CTRL);
    localparam logic [31:0] STAT_END = CTRL_END + 32'(4 * NUM_STAT);

    logic [31:0] word_addr_s;

    // Word-align the address and classify it into a register region.
    always_comb begin
        word_addr_s = 32'(addr_i) & ~32'h0000_0003;
        region_o    = REG_NONE;
        index_o     = 32'd0;
        valid_o     = 1'b1;
        if (word_addr_s == OFF_VERSION) begin
            region_o = REG_VERSION;
        end else if (word_addr_s == OFF_PULSE) begin
            region_o = REG_PULSE;
        end else if (word_addr_s == OFF_EVT_STATUS) begin
            region_o = REG_EVT_STATUS;
        end else if (word_addr_s == OFF_EVT_ENABLE) begin
            region_o = REG_EVT_ENABLE;
        end else if (word_addr_s >= OFF_CTRL_BASE && word_addr_s < CTRL_END) begin
            region_o = REG_CTRL;
            index_o  = (word_addr_s - OFF_CTRL_BASE) >> 2;
        end else if (word_addr_s >= CTRL_END && word_addr_s < STAT_END) begin
            region_o = REG_STAT;
            index_o  = (word_addr_s - CTRL_END) >> 2;
        end else begin
            valid_o  = 1'b0;
        end
    end

endmodule

// File: rtl/axi_lite_reg_bank.sv
// AXI4-Lite host register bank: control words, status words, self-clearing
// pulse bits and sticky W1C event flags with a level interrupt.
module axi_lite_reg_bank
    import axi_lite_reg_bank_pkg::*;
#(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 8,
    parameter int          NUM_CTRL           = 4,
    parameter int          NUM_STAT           = 4,
    parameter int          NUM_EVT            = 8,
    parameter logic [31:0] CTRL_RST_VAL       = 32'h0000_0000,
    parameter logic [31:0] VERSION            = 32'h0001_0000
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    output logic [NUM_CTRL*32-1:0]            ctrl_o,
    output logic [NUM_CTRL-1:0]               ctrl_wr_o,
    input  logic [NUM_STAT*32-1:0]            stat_i,
    input  logic [NUM_EVT-1:0]                evt_i,
    output logic [31:0]                       pulse_o,
    output logic                              irq_o
);

    region_e wr_region_s, rd_region_s;
    logic [31:0] wr_index_s, rd_index_s;
    logic wr_valid_s, rd_valid_s, wr_en_s, rd_en_s, unused_s;
    logic [31:0] wr_mask_s, rd_data_s;
    logic [1:0] rd_resp_s;
    logic [NUM_EVT-1:0] evt_clr_s;

    logic aw_rdy_q, aw_rdy_d, bvalid_q, bvalid_d, ar_rdy_q, ar_rdy_d, rvalid_q, rvalid_d;
    logic irq_q, irq_d;
    logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d, pulse_q, pulse_d;
    logic [31:0] ctrl_q [NUM_CTRL];
    logic [31:0] ctrl_d [NUM_CTRL];
    logic [NUM_CTRL-1:0] ctrl_wr_q, ctrl_wr_d;
    logic [NUM_EVT-1:0] evt_status_q, evt_status_d, evt_enable_q, evt_enable_d;

    axi_lite_reg_bank_decode #(
        .ADDR_WIDTH (C_S_AXI_ADDR_WIDTH),
        .NUM_CTRL   (NUM_CTRL),
        .NUM_STAT   (NUM_STAT)
    ) u_wr_decode (
        .addr_i   (s00_axi_awaddr),
        .region_o (wr_region_s),
        .index_o  (wr_index_s),
        .valid_o  (wr_valid_s)
    );

    axi_lite_reg_bank_decode #(
        .ADDR_WIDTH (C_S_AXI_ADDR_WIDTH),
        .NUM_CTRL   (NUM_CTRL),
        .NUM_STAT   (NUM_STAT)
    ) u_rd_decode (
        .addr_i   (s00_axi_araddr),
        .region_o (rd_region_s),
        .index_o  (rd_index_s),
        .valid_o  (rd_valid_s)
    );

    assign unused_s  = ^{s00_axi_awprot, s00_axi_arprot, rd_valid_s};
    assign wr_en_s   = aw_rdy_q & s00_axi_awvalid & s00_axi_wvalid;
    assign rd_en_s   = ar_rdy_q & s00_axi_arvalid;
    assign wr_mask_s = strb_to_mask(s00_axi_wstrb);

    // Read data mux: sampled into rdata at the read handshake edge, so a
    // same-edge write is not yet visible.
    always_comb begin
        rd_data_s = 32'd0;
        rd_resp_s = RESP_OKAY;
        case (rd_region_s)
            REG_VERSION:    rd_data_s = VERSION;
            REG_PULSE:      rd_data_s = 32'd0;
            REG_EVT_STATUS: rd_data_s = 32'(evt_status_q);
            REG_EVT_ENABLE: rd_data_s = 32'(evt_enable_q);
            REG_CTRL: begin
                for (int i = 0; i < NUM_CTRL; i++) begin
                    if (rd_index_s == unsigned'(i)) rd_data_s = ctrl_q[i];
                    else                            rd_data_s = rd_data_s;
                end
            end
            REG_STAT: begin
                for (int j = 0; j < NUM_STAT; j++) begin
                    if (rd_index_s == unsigned'(j)) rd_data_s = stat_i[32*j +: 32];
                    else                            rd_data_s = rd_data_s;
                end
            end
            default:        rd_resp_s = RESP_SLVERR;
        endcase
    end

    // Next-state for channel handshakes, register writes and event logic.
    always_comb begin
        aw_rdy_d     = s00_axi_awvalid & s00_axi_wvalid & ~bvalid_q & ~aw_rdy_q;
        ar_rdy_d     = s00_axi_arvalid & ~rvalid_q & ~ar_rdy_q;
        bvalid_d     = wr_en_s | (bvalid_q & ~s00_axi_bready);
        rvalid_d     = rd_en_s | (rvalid_q & ~s00_axi_rready);
        bresp_d      = bresp_q;
        rdata_d      = rdata_q;
        rresp_d      = rresp_q;
        pulse_d      = 32'd0;
        ctrl_wr_d    = '0;
        ctrl_d       = ctrl_q;
        evt_enable_d = evt_enable_q;
        evt_clr_s    = '0;
        if (wr_en_s) begin
            bresp_d = wr_valid_s ? RESP_OKAY : RESP_SLVERR;
            case (wr_region_s)
                REG_PULSE:      pulse_d = s00_axi_wdata & wr_mask_s;
                REG_EVT_STATUS: evt_clr_s = s00_axi_wdata[NUM_EVT-1:0] & wr_mask_s[NUM_EVT-1:0];
                REG_EVT_ENABLE: evt_enable_d = (evt_enable_q & ~wr_mask_s[NUM_EVT-1:0])
                                             | (s00_axi_wdata[NUM_EVT-1:0] & wr_mask_s[NUM_EVT-1:0]);
                REG_CTRL: begin
                    for (int i = 0; i < NUM_CTRL; i++) begin
                        if (wr_index_s == unsigned'(i)) begin
                            ctrl_d[i]    = (ctrl_q[i] & ~wr_mask_s) | (s00_axi_wdata & wr_mask_s);
                            ctrl_wr_d[i] = 1'b1;
                        end else begin
                            ctrl_d[i]    = ctrl_q[i];
                        end
                    end
                end
                default:        bresp_d = bresp_d;
            endcase
        end else begin
            bresp_d = bresp_q;
        end
        if (rd_en_s) begin
            rdata_d = rd_data_s;
            rresp_d = rd_resp_s;
        end else begin
            rdata_d = rdata_q;
        end
        // Set wins over clear on the same bit.
        evt_status_d = (evt_status_q & ~evt_clr_s) | evt_i;
        irq_d        = |(evt_status_q & evt_enable_q);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            aw_rdy_q     <= 1'b0;
            ar_rdy_q     <= 1'b0;
            bvalid_q     <= 1'b0;
            rvalid_q     <= 1'b0;
            bresp_q      <= 2'b00;
            rresp_q      <= 2'b00;
            rdata_q      <= 32'd0;
            pulse_q      <= 32'd0;
            ctrl_wr_q    <= '0;
            evt_status_q <= '0;
            evt_enable_q <= '0;
            irq_q        <= 1'b0;
            for (int i = 0; i < NUM_CTRL; i++) ctrl_q[i] <= CTRL_RST_VAL;
        end else begin
            aw_rdy_q     <= aw_rdy_d;
            ar_rdy_q     <= ar_rdy_d;
            bvalid_q     <= bvalid_d;
            rvalid_q     <= rvalid_d;
            bresp_q      <= bresp_d;
            rresp_q      <= rresp_d;
            rdata_q      <= rdata_d;
            pulse_q      <= pulse_d;
            ctrl_wr_q    <= ctrl_wr_d;
            evt_status_q <= evt_status_d;
            evt_enable_q <= evt_enable_d;
            irq_q        <= irq_d;
            for (int i = 0; i < NUM_CTRL; i++) ctrl_q[i] <= ctrl_d[i];
        end
    end

    for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl_out
        assign ctrl_o[32*g +: 32] = ctrl_q[g];
    end

    assign s00_axi_awready = aw_rdy_q;
    assign s00_axi_wready  = aw_rdy_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = bresp_q;
    assign s00_axi_arready = ar_rdy_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = rresp_q;
    assign ctrl_wr_o       = ctrl_wr_q;
    assign pulse_o         = pulse_q;
    assign irq_o           = irq_q;

endmodule

// File: tb/tb_axi_lite_reg_bank.sv
// Self-checking bench for axi_lite_reg_bank: vector table plus hand-written
// sequences, with response expectations queued at issue and popped on valid.
module tb_axi_lite_reg_bank;

    logic         clk, rst_n;
    logic [7:0]   awaddr, araddr;
    logic [2:0]   awprot, arprot;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [31:0]  wdata, rdata, pulse;
    logic [3:0]   wstrb;
    logic [1:0]   bresp, rresp;
    logic [127:0] ctrl, stat;
    logic [3:0]   ctrl_wr;
    logic [7:0]   evt;
    logic         irq;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    typedef struct packed {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    logic [1:0] exp_b_q [$];
    rexp_t      exp_r_q [$];
    vec_t       vecs [18];

    axi_lite_reg_bank dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .ctrl_o          (ctrl),
        .ctrl_wr_o       (ctrl_wr),
        .stat_i          (stat),
        .evt_i           (evt),
        .pulse_o         (pulse),
        .irq_o           (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_issue(input logic [7:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] resp);
        int n = 0;
        exp_b_q.push_back(resp);
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        while (!awready && n < 16) begin tick(); n++; end
        check("awready", awready, 1'b1);
        check("wready", wready, 1'b1);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic wr_resp(input int delay);
        logic [1:0] exp;
        for (int k = 0; k < delay; k++) begin
            check("bvalid_hold", bvalid, 1'b1);
            tick();
        end
        check("bvalid", bvalid, 1'b1);
        if (exp_b_q.size() > 0) begin
            exp = exp_b_q.pop_front();
            check("bresp", bresp, exp);
        end else begin
            check("bresp_queue", 1'b0, 1'b1);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("bvalid_clear", bvalid, 1'b0);
    endtask

    task automatic rd_issue(input logic [7:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp);
        int n = 0;
        exp_r_q.push_back('{data: exp_data, resp: exp_resp});
        araddr = addr; arvalid = 1'b1;
        while (!arready && n < 16) begin tick(); n++; end
        check("arready", arready, 1'b1);
        tick();
        arvalid = 1'b0;
    endtask

    task automatic rd_resp();
        int n = 0;
        rexp_t e;
        while (!rvalid && n < 16) begin tick(); n++; end
        check("rvalid", rvalid, 1'b1);
        if (exp_r_q.size() > 0) begin
            e = exp_r_q.pop_front();
            check("rdata", rdata, e.data);
            check("rresp", rresp, e.resp);
        end else begin
            check("rdata_queue", 1'b0, 1'b1);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("rvalid_clear", rvalid, 1'b0);
    endtask

    task automatic rd(input logic [7:0] addr, input logic [31:0] d, input logic [1:0] r);
        rd_issue(addr, d, r);
        rd_resp();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{1'b0, 8'h00, 32'h0,         4'h0, 32'h0001_0000, 2'b00};
        vecs[1]  = '{1'b0, 8'h10, 32'h0,         4'h0, 32'h0000_0000, 2'b00};
        vecs[2]  = '{1'b1, 8'h18, 32'hDEAD_BEEF, 4'hF, 32'h0,         2'b00};
        vecs[3]  = '{1'b0, 8'h18, 32'h0,         4'h0, 32'hDEAD_BEEF, 2'b00};
        vecs[4]  = '{1'b1, 8'h18, 32'h1122_3344, 4'hA, 32'h0,         2'b00};
        vecs[5]  = '{1'b0, 8'h18, 32'h0,         4'h0, 32'h11AD_33EF, 2'b00};
        vecs[6]  = '{1'b1, 8'h1C, 32'hFFFF_FFFF, 4'h0, 32'h0,         2'b00};
        vecs[7]  = '{1'b0, 8'h1C, 32'h0,         4'h0, 32'h0000_0000, 2'b00};
        vecs[8]  = '{1'b1, 8'h00, 32'h1234_5678, 4'hF, 32'h0,         2'b00};
        vecs[9]  = '{1'b0, 8'h03, 32'h0,         4'h0, 32'h0001_0000, 2'b00};
        vecs[10] = '{1'b1, 8'h20, 32'hFFFF_FFFF, 4'hF, 32'h0,         2'b00};
        vecs[11] = '{1'b0, 8'h20, 32'h0,         4'h0, 32'h1111_0000, 2'b00};
        vecs[12] = '{1'b0, 8'h2C, 32'h0,         4'h0, 32'h4444_0003, 2'b00};
        vecs[13] = '{1'b0, 8'h30, 32'h0,         4'h0, 32'h0000_0000, 2'b10};
        vecs[14] = '{1'b1, 8'h30, 32'hFFFF_FFFF, 4'hF, 32'h0,         2'b10};
        vecs[15] = '{1'b1, 8'h0C, 32'h0000_01FF, 4'hF, 32'h0,         2'b00};
        vecs[16] = '{1'b0, 8'h0C, 32'h0,         4'h0, 32'h0000_00FF, 2'b00};
        vecs[17] = '{1'b0, 8'h04, 32'h0,         4'h0, 32'h0000_0000, 2'b00};

        rst_n = 1'b0;
        awaddr = 8'h00; araddr = 8'h00; awprot = 3'd0; arprot = 3'd0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
        wdata = 32'd0; wstrb = 4'h0; evt = 8'h00;
        stat = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", awready, 1'b0);
        check("rst_bvalid", bvalid, 1'b0);
        check("rst_arready", arready, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_ctrl", ctrl, 128'h0);
        check("rst_ctrl_wr", ctrl_wr, 4'h0);
        check("rst_pulse", pulse, 32'h0);
        check("rst_irq", irq, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Partial-strobe control write, strobe and bvalid hold
        wr_issue(8'h14, 32'hA5A5_1234, 4'b0011, 2'b00);
        check("ctrl1_value", ctrl[63:32], 32'h0000_1234);
        check("ctrl_wr_pulse", ctrl_wr, 4'b0010);
        tick();
        check("ctrl_wr_clear", ctrl_wr, 4'b0000);
        wr_resp(2);

        // Self-clearing pulse bits
        wr_issue(8'h04, 32'h8000_0001, 4'hF, 2'b00);
        check("pulse_high", pulse, 32'h8000_0001);
        tick();
        check("pulse_low", pulse, 32'h0);
        wr_resp(0);
        rd(8'h04, 32'h0, 2'b00);

        for (int i = 0; i < 18; i++) begin
            if (vecs[i].wr) begin
                wr_issue(vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].exp_resp);
                wr_resp(i % 3);
            end else begin
                rd(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp);
            end
        end
        check("ctrl_after_table", ctrl, {32'h0, 32'h11AD_33EF, 32'h0000_1234, 32'h0});

        // Sticky event, interrupt latency, set-beats-clear, W1C
        wr_issue(8'h0C, 32'h0000_0008, 4'hF, 2'b00);
        wr_resp(0);
        evt = 8'h08;
        tick();
        evt = 8'h00;
        check("irq_latency", irq, 1'b0);
        tick();
        check("irq_rise", irq, 1'b1);
        rd(8'h08, 32'h0000_0008, 2'b00);
        evt = 8'h08;
        wr_issue(8'h08, 32'h0000_0008, 4'hF, 2'b00);
        evt = 8'h00;
        wr_resp(0);
        rd(8'h08, 32'h0000_0008, 2'b00);
        check("irq_held", irq, 1'b1);
        wr_issue(8'h08, 32'h0000_0008, 4'h1, 2'b00);
        check("irq_before_fall", irq, 1'b1);
        tick();
        check("irq_fall", irq, 1'b0);
        wr_resp(0);
        rd(8'h08, 32'h0, 2'b00);

        // Unmapped top-of-map access
        rd(8'hFC, 32'h0, 2'b10);
        wr_issue(8'hFC, 32'hFFFF_FFFF, 4'hF, 2'b10);
        wr_resp(1);
        check("unmapped_no_change", ctrl, {32'h0, 32'h11AD_33EF, 32'h0000_1234, 32'h0});

        // Simultaneous read and write of CTRL[0]
        wr_issue(8'h10, 32'hCAFE_0000, 4'hF, 2'b00);
        wr_resp(0);
        exp_r_q.push_back('{data: 32'hCAFE_0000, resp: 2'b00});
        araddr = 8'h10; arvalid = 1'b1;
        wr_issue(8'h10, 32'h1234_5678, 4'hF, 2'b00);
        arvalid = 1'b0;
        check("concurrent_rvalid", rvalid, 1'b1);
        rd_resp();
        check("concurrent_ctrl0", ctrl[31:0], 32'h1234_5678);
        wr_resp(0);

        // Reset with both responses pending
        wr_issue(8'h18, 32'h5555_5555, 4'hF, 2'b00);
        rd_issue(8'h10, 32'h1234_5678, 2'b00);
        check("pre_reset_bvalid", bvalid, 1'b1);
        check("pre_reset_rvalid", rvalid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_bvalid", bvalid, 1'b0);
        check("reset_rvalid", rvalid, 1'b0);
        check("reset_ctrl", ctrl, 128'h0);
        exp_b_q.delete();
        exp_r_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        rd(8'h10, 32'h0, 2'b00);
        check("queues_drained", exp_b_q.size() + exp_r_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
